y86_decode_stage: RTL and testbench

Decode stage of the Y86-64 processor. It sits directly downstream of instruction fetch and registers the fetch outputs (icode, ifun, regA, regB, valC, valP, status flags). It derives the source and destination register IDs and reads the 15-entry register file, which it owns. It presents one registered decode bundle per accepted instruction to execute. Writeback drives two register-file write ports, E and M, into this block.

---
 rtl/y86_pkg.sv | 43 ++++
 rtl/y86_regfile.sv | 74 +++++++
 rtl/y86_decode_stage.sv | 153 +++++++++++++++
 tb/tb_y86_decode_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: instruction codes, register IDs, status codes, word type.
package y86_pkg;

  typedef logic [63:0] word_t;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Fetch status priority: a memory error outranks a bad opcode, which outranks halt.
  function automatic logic [2:0] f_stat(input logic mem_err, input logic instr_ok,
                                        input logic [3:0] ic);
    logic [2:0] s;
    if (mem_err) begin
      s = STAT_ADR;
    end else if (!instr_ok) begin
      s = STAT_INS;
    end else if (ic == I_HALT) begin
      s = STAT_HLT;
    end else begin
      s = STAT_AOK;
    end
    return s;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: NREG x 64-bit, two combinational read ports, write ports E and M (M wins).
// DECODE_WRITE_BYPASS_EN forwards same-edge write data onto the read ports.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'd1024,
  parameter int          NREG       = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  rdA_addr,
  input  logic [3:0]  rdB_addr,
  output word_t       rdA_data,
  output word_t       rdB_data,
  input  logic        wE_en,
  input  logic [3:0]  wE_addr,
  input  word_t       wE_data,
  input  logic        wM_en,
  input  logic [3:0]  wM_addr,
  input  word_t       wM_data
);

  word_t r_regs [0:NREG-1];
  word_t w_rawA;
  word_t w_rawB;

`ifdef DECODE_WRITE_BYPASS_EN
  function automatic word_t f_bypass(input logic [3:0] a, input word_t cur,
                                     input logic e_en, input logic [3:0] e_addr, input word_t e_data,
                                     input logic m_en, input logic [3:0] m_addr, input word_t m_data);
    word_t v;
    if (a != RNONE && m_en && m_addr == a) begin
      v = m_data;
    end else if (a != RNONE && e_en && e_addr == a) begin
      v = e_data;
    end else begin
      v = cur;
    end
    return v;
  endfunction
`endif

  // Storage update; address F never matches an index so such writes drop out naturally.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NREG; i++) begin
      if (!reset_n) begin
        r_regs[i] <= (4'(i) == RRSP) ? STACK_INIT : 64'd0;
      end else if (wM_en && wM_addr == 4'(i)) begin
        r_regs[i] <= wM_data;
      end else if (wE_en && wE_addr == 4'(i)) begin
        r_regs[i] <= wE_data;
      end
    end
  end

  // Read mux: ID F (or any ID beyond the file) reads as zero.
  always_comb begin
    w_rawA = 64'd0;
    w_rawB = 64'd0;
    for (int i = 0; i < NREG; i++) begin
      w_rawA = (rdA_addr == 4'(i)) ? r_regs[i] : w_rawA;
      w_rawB = (rdB_addr == 4'(i)) ? r_regs[i] : w_rawB;
    end
  end

`ifdef DECODE_WRITE_BYPASS_EN
  assign rdA_data = f_bypass(rdA_addr, w_rawA, wE_en, wE_addr, wE_data, wM_en, wM_addr, wM_data);
  assign rdB_data = f_bypass(rdB_addr, w_rawB, wE_en, wE_addr, wE_data, wM_en, wM_addr, wM_data);
`else
  assign rdA_data = w_rawA;
  assign rdB_data = w_rawB;
`endif

endmodule

// File: rtl/y86_decode_stage.sv
// Y86-64 decode stage: derives register IDs, reads the owned register file, registers one bundle per accept.
// Define DECODE_WRITE_BYPASS_EN to let an accept see register writes landing on the same edge.
module y86_decode_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'd1024,
  parameter int          NREG       = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  regA,
  input  logic [3:0]  regB,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        instruct_valid,
  input  logic        mem_error,
  input  logic        stall,
  input  logic        wE_en,
  input  logic [3:0]  wE_addr,
  input  logic [63:0] wE_data,
  input  logic        wM_en,
  input  logic [3:0]  wM_addr,
  input  logic [63:0] wM_data,
  output logic        out_valid,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [63:0] d_valC,
  output logic [63:0] d_valP,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB,
  output logic [2:0]  d_stat,
  output logic        halted
);

  logic [3:0] w_srcA, w_srcB, w_dstE, w_dstM;
  word_t      w_rdA, w_rdB, w_valA;
  logic [2:0] w_stat;
  logic       w_accept;

  logic       r_out_valid, r_halted;
  logic [3:0] r_icode, r_ifun, r_srcA, r_srcB, r_dstE, r_dstM;
  word_t      r_valC, r_valP, r_valA, r_valB;
  logic [2:0] r_stat;

  y86_regfile #(
    .STACK_INIT (STACK_INIT),
    .NREG       (NREG)
  ) u_regfile (
    .clock    (clock),
    .reset_n  (reset_n),
    .rdA_addr (w_srcA),
    .rdB_addr (w_srcB),
    .rdA_data (w_rdA),
    .rdB_data (w_rdB),
    .wE_en    (wE_en),
    .wE_addr  (wE_addr),
    .wE_data  (wE_data),
    .wM_en    (wM_en),
    .wM_addr  (wM_addr),
    .wM_data  (wM_data)
  );

  assign in_ready = !stall && !r_halted;
  assign w_accept = in_valid && in_ready;
  assign w_stat   = f_stat(mem_error, instruct_valid, icode);

  // Register IDs per opcode; cmov always names regB as dstE, the condition is resolved later.
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (icode)
      I_RRMOVQ: begin w_srcA = regA; w_dstE = regB; end
      I_IRMOVQ: begin w_dstE = regB; end
      I_RMMOVQ: begin w_srcA = regA; w_srcB = regB; end
      I_MRMOVQ: begin w_srcB = regB; w_dstM = regA; end
      I_OPQ:    begin w_srcA = regA; w_srcB = regB; w_dstE = regB; end
      I_CALL:   begin w_srcB = RRSP; w_dstE = RRSP; end
      I_RET:    begin w_srcA = RRSP; w_srcB = RRSP; w_dstE = RRSP; end
      I_PUSHQ:  begin w_srcA = regA; w_srcB = RRSP; w_dstE = RRSP; end
      I_POPQ:   begin w_srcA = RRSP; w_srcB = RRSP; w_dstE = RRSP; w_dstM = regA; end
      default:  begin w_srcA = RNONE; end
    endcase
    if (icode == I_CALL || icode == I_JXX) begin
      w_valA = valP;
    end else begin
      w_valA = w_rdA;
    end
  end

  // Output bundle register and sticky halt flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      r_icode     <= I_NOP;
      r_ifun      <= 4'h0;
      r_valC      <= 64'd0;
      r_valP      <= 64'd0;
      r_valA      <= 64'd0;
      r_valB      <= 64'd0;
      r_srcA      <= RNONE;
      r_srcB      <= RNONE;
      r_dstE      <= RNONE;
      r_dstM      <= RNONE;
      r_stat      <= STAT_AOK;
    end else begin
      if (!stall) begin
        r_out_valid <= w_accept;
      end
      if (w_accept) begin
        r_icode <= icode;
        r_ifun  <= ifun;
        r_valC  <= valC;
        r_valP  <= valP;
        r_srcA  <= w_srcA;
        r_srcB  <= w_srcB;
        r_dstE  <= w_dstE;
        r_dstM  <= w_dstM;
        r_valA  <= w_valA;
        r_valB  <= w_rdB;
        r_stat  <= w_stat;
        if (w_stat != STAT_AOK) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign halted    = r_halted;
  assign d_icode   = r_icode;
  assign d_ifun    = r_ifun;
  assign d_valC    = r_valC;
  assign d_valP    = r_valP;
  assign d_srcA    = r_srcA;
  assign d_srcB    = r_srcB;
  assign d_dstE    = r_dstE;
  assign d_dstM    = r_dstM;
  assign d_valA    = r_valA;
  assign d_valB    = r_valB;
  assign d_stat    = r_stat;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Self-checking bench for y86_decode_stage: directed scenarios plus random traffic against a rule-table model.
module tb_y86_decode_stage;

  localparam logic [63:0] STACK_INIT = 64'd1024;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode, ifun, regA, regB;
  logic [63:0] valC, valP;
  logic        instruct_valid, mem_error, stall;
  logic        wE_en, wM_en;
  logic [3:0]  wE_addr, wM_addr;
  logic [63:0] wE_data, wM_data;
  logic        out_valid;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valP, d_valA, d_valB;
  logic [2:0]  d_stat;
  logic        halted;

  y86_decode_stage #(.STACK_INIT(STACK_INIT), .NREG(15)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .regA(regA), .regB(regB), .valC(valC), .valP(valP),
    .instruct_valid(instruct_valid), .mem_error(mem_error), .stall(stall),
    .wE_en(wE_en), .wE_addr(wE_addr), .wE_data(wE_data),
    .wM_en(wM_en), .wM_addr(wM_addr), .wM_data(wM_data),
    .out_valid(out_valid), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valP(d_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .d_valA(d_valA), .d_valB(d_valB), .d_stat(d_stat), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [63:0] m_reg [0:14];
  logic        m_ov, m_halted;
  logic [3:0]  m_icode, m_ifun, m_srcA, m_srcB, m_dstE, m_dstM;
  logic [63:0] m_valC, m_valP, m_valA, m_valB;
  logic [2:0]  m_stat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] ref_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] ref_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? STACK_INIT : 64'd0;
    m_ov = 1'b0; m_halted = 1'b0;
    m_icode = 4'h1; m_ifun = 4'h0; m_valC = 64'd0; m_valP = 64'd0;
    m_valA = 64'd0; m_valB = 64'd0;
    m_srcA = 4'hF; m_srcB = 4'hF; m_dstE = 4'hF; m_dstM = 4'hF;
    m_stat = 3'd1;
  endtask

  function automatic logic [63:0] read_pre(input logic [3:0] id);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 15; i++) if (id == 4'(i)) v = m_reg[i];
    return v;
  endfunction

  // Value a register reads after this edge's writes (M applied after E, so M wins)
  function automatic logic [63:0] read_post(input logic [3:0] id);
    logic [63:0] v;
    v = read_pre(id);
    if (id != 4'hF && wE_en && wE_addr == id) v = wE_data;
    if (id != 4'hF && wM_en && wM_addr == id) v = wM_data;
    return v;
  endfunction

  function automatic logic [63:0] read_src(input logic [3:0] id);
`ifdef DECODE_WRITE_BYPASS_EN
    return read_post(id);
`else
    return read_pre(id);
`endif
  endfunction

  task automatic check_all();
    chk("out_valid", out_valid, m_ov);
    chk("halted", halted, m_halted);
    chk("d_icode", d_icode, m_icode);
    chk("d_ifun", d_ifun, m_ifun);
    chk("d_valC", d_valC, m_valC);
    chk("d_valP", d_valP, m_valP);
    chk("d_srcA", d_srcA, m_srcA);
    chk("d_srcB", d_srcB, m_srcB);
    chk("d_dstE", d_dstE, m_dstE);
    chk("d_dstM", d_dstM, m_dstM);
    chk("d_valA", d_valA, m_valA);
    chk("d_valB", d_valB, m_valB);
    chk("d_stat", d_stat, m_stat);
  endtask

  // Predict the edge from current inputs, clock it, then compare every output.
  task automatic tick();
    logic        acc;
    logic [63:0] nreg [0:14];
    #1;
    if (reset_n) chk("in_ready", in_ready, !stall && !m_halted);
    if (!reset_n) begin
      model_reset();
    end else begin
      acc = in_valid && !stall && !m_halted;
      for (int i = 0; i < 15; i++) nreg[i] = read_post(4'(i));
      if (!stall) m_ov = acc;
      if (acc) begin
        m_icode = icode; m_ifun = ifun; m_valC = valC; m_valP = valP;
        m_srcA = ref_srcA(icode, regA);
        m_srcB = ref_srcB(icode, regB);
        m_dstE = ref_dstE(icode, regB);
        m_dstM = ref_dstM(icode, regA);
        m_valA = (icode == 4'h8 || icode == 4'h7) ? valP : read_src(m_srcA);
        m_valB = read_src(m_srcB);
        m_stat = mem_error ? 3'd3 : (!instruct_valid ? 3'd4 : (icode == 4'h0 ? 3'd2 : 3'd1));
        if (m_stat != 3'd1) m_halted = 1'b1;
      end
      for (int i = 0; i < 15; i++) m_reg[i] = nreg[i];
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle();
    in_valid = 1'b0; stall = 1'b0; wE_en = 1'b0; wM_en = 1'b0;
    instruct_valid = 1'b1; mem_error = 1'b0;
  endtask

  task automatic feed(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] vc, input logic [63:0] vp);
    in_valid = 1'b1; icode = ic; ifun = 4'h0; regA = ra; regB = rb; valC = vc; valP = vp;
    instruct_valid = 1'b1; mem_error = 1'b0;
  endtask

  initial begin
    logic [63:0] held_valP;
    reset_n = 1'b0;
    icode = 4'h1; ifun = 4'h0; regA = 4'hF; regB = 4'hF; valC = 64'd0; valP = 64'd0;
    wE_addr = 4'h0; wM_addr = 4'h0; wE_data = 64'd0; wM_data = 64'd0;
    idle();
    model_reset();
    tick();
    tick();
    chk("rst_icode_nop", d_icode, 64'd1);
    chk("rst_stat_aok", d_stat, 64'd1);
    reset_n = 1'b1;

    // pushq %rsp right after reset
    feed(4'hA, 4'h4, 4'hF, 64'd0, 64'h10);
    tick();
    chk("push_valA", d_valA, 64'd1024);
    chk("push_valB", d_valB, 64'd1024);
    chk("push_dstE", d_dstE, 64'd4);
    idle();

    // write r2 via E, r3 via M, then OPq
    wE_en = 1'b1; wE_addr = 4'h2; wE_data = 64'd5;
    tick();
    idle();
    wM_en = 1'b1; wM_addr = 4'h3; wM_data = 64'd7;
    tick();
    idle();
    feed(4'h6, 4'h2, 4'h3, 64'd0, 64'h20);
    tick();
    chk("opq_valA", d_valA, 64'd5);
    chk("opq_valB", d_valB, 64'd7);
    chk("opq_dstE", d_dstE, 64'd3);
    chk("opq_dstM", d_dstM, 64'hF);
    idle();

    // E/M collision on r1, M must win
    wE_en = 1'b1; wE_addr = 4'h1; wE_data = 64'hAA;
    wM_en = 1'b1; wM_addr = 4'h1; wM_data = 64'hBB;
    tick();
    idle();
    tick();
    feed(4'h4, 4'h1, 4'h0, 64'h8, 64'h30);
    tick();
    chk("collision_valA", d_valA, 64'hBB);
    idle();

    // write to F is dropped; accept on same edge as a write to r6
    wE_en = 1'b1; wE_addr = 4'hF; wE_data = 64'h55;
    tick();
    idle();
    feed(4'h6, 4'h6, 4'h0, 64'd0, 64'h40);
    wE_en = 1'b1; wE_addr = 4'h6; wE_data = 64'd9;
    tick();
`ifdef DECODE_WRITE_BYPASS_EN
    chk("bypass_valA", d_valA, 64'd9);
`else
    chk("bypass_valA", d_valA, 64'd0);
`endif
    idle();
    tick();

    // stall three cycles with a bundle waiting, then release
    held_valP = d_valP;
    feed(4'h7, 4'hF, 4'hF, 64'h100, 64'h50);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_valP", d_valP, held_valP);
    end
    stall = 1'b0;
    tick();
    chk("release_icode", d_icode, 64'd7);
    chk("release_valA", d_valA, 64'h50);
    idle();

    // call passes valP as valA
    feed(4'h8, 4'hF, 4'hF, 64'h200, 64'h1234);
    tick();
    chk("call_valA", d_valA, 64'h1234);
    idle();

    // random traffic, only AOK bundles
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      icode = 4'($urandom_range(1, 11));
      ifun = 4'($urandom_range(0, 15));
      regA = 4'($urandom_range(0, 15));
      regB = 4'($urandom_range(0, 15));
      valC = {$urandom, $urandom};
      valP = {$urandom, $urandom};
      instruct_valid = 1'b1; mem_error = 1'b0;
      wE_en = $urandom_range(0, 1) == 1;
      wE_addr = 4'($urandom_range(0, 15));
      wE_data = {$urandom, $urandom};
      wM_en = $urandom_range(0, 1) == 1;
      wM_addr = ($urandom_range(0, 3) == 0) ? wE_addr : 4'($urandom_range(0, 15));
      wM_data = {$urandom, $urandom};
      tick();
    end
    idle();
    tick();

    // halt: stat HLT, sticky halted, later bundles ignored
    feed(4'h0, 4'hF, 4'hF, 64'd0, 64'h60);
    tick();
    chk("halt_stat", d_stat, 64'd2);
    chk("halt_flag", halted, 64'd1);
    feed(4'h6, 4'h2, 4'h3, 64'd0, 64'h70);
    tick();
    chk("halt_ready_low", in_ready, 64'd0);
    chk("halt_ignores_icode", d_icode, 64'd0);
    tick();

    // reset clears halt; mem_error with bad opcode gives ADR
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("reset_clears_halt", halted, 64'd0);
    feed(4'h6, 4'h1, 4'h2, 64'd0, 64'h80);
    mem_error = 1'b1; instruct_valid = 1'b0;
    tick();
    chk("adr_stat", d_stat, 64'd3);
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    feed(4'hC, 4'h1, 4'h2, 64'd0, 64'h90);
    instruct_valid = 1'b0;
    tick();
    chk("ins_stat", d_stat, 64'd4);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
